// File: rtl/img_loader.sv
// img_loader: frame buffer that sits between a pixel stream and the ATCONV engine.
//
// Pixels arrive on a valid/ready stream and fill a 2**AW-deep buffer in row-major
// order. Once the final address is written, the frame is offered to the engine with
// 'ready'. The engine claims it by raising 'busy' and releases it by dropping 'busy',
// after which loading resumes. While the engine owns the frame, the buffer stays frozen.
//
// Ports
//   clk        single clock, rising edge
//   reset      asynchronous, active-high; also clears the buffer
//   s_valid    upstream pixel valid
//   s_ready    loader accepts a pixel this cycle (high only while loading)
//   s_data     pixel value
//   s_last     final pixel of a frame; qualified by s_valid && s_ready
//   ready      registered frame-available request to the engine
//   busy       engine is processing the offered frame
//   iaddr      engine read address
//   idata      buffer[iaddr], combinational
//   err        sticky framing error (s_last seen before the final address)
//   frame_cnt  completed hand-offs, wraps 255 -> 0
module img_loader #(
  parameter int unsigned DW = 13,
  parameter int unsigned AW = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  output logic          err,
  output logic [7:0]    frame_cnt
);

  localparam int unsigned Depth = 2 ** AW;
  localparam logic [AW-1:0] LastAddr = '1;

  typedef enum logic [1:0] {
    StLoad,
    StOffer,
    StRun
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic          err_q, err_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          ready_q;
  logic          accept;

  logic [DW-1:0] mem_q [Depth];

  // Next-state and stream handshake. s_ready decodes registered state only.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    s_ready = 1'b0;
    accept  = 1'b0;
    case (state_q)
      StLoad: begin
        s_ready = 1'b1;
        accept  = s_valid;
        if (s_valid) begin
          if (wptr_q == LastAddr) begin
            // Final address completes the frame whether or not s_last accompanies it.
            wptr_d  = '0;
            state_d = StOffer;
          end else if (s_last) begin
            // Early end of frame: keep the written pixel, drop the frame, restart at 0.
            err_d  = 1'b1;
            wptr_d = '0;
          end else begin
            wptr_d = wptr_q + AW'(1);
          end
        end
      end
      StOffer: begin
        if (busy) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!busy) begin
          state_d = StLoad;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StLoad;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StLoad;
      wptr_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      // Registered so that ready has no combinational path from busy or s_valid.
      ready_q <= (state_d == StOffer);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (accept) begin
      mem_q[wptr_q] <= s_data;
    end
  end

  assign idata     = mem_q[iaddr];
  assign ready     = ready_q;
  assign err       = err_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_img_loader.sv
// Self-checking bench for img_loader. A transaction-level model (pixel array plus
// frame phase, error and hand-off counters) predicts every output; a second,
// small-depth instance exercises the 8-bit frame counter wrap in few cycles.
module tb_img_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_valid, s_last, busy;
  logic [12:0] s_data;
  logic [11:0] iaddr;
  logic        s_ready, ready, err;
  logic [12:0] idata;
  logic [7:0]  frame_cnt;

  logic        sv2, sl2, busy2;
  logic [12:0] sd2;
  logic [3:0]  ia2;
  logic        sr2, rd2, er2;
  logic [12:0] id2;
  logic [7:0]  fc2;

  always #5 clk = ~clk;

  img_loader #(.DW(13), .AW(12)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .ready     (ready),
    .busy      (busy),
    .iaddr     (iaddr),
    .idata     (idata),
    .err       (err),
    .frame_cnt (frame_cnt)
  );

  img_loader #(.DW(13), .AW(4)) dut_small (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (sv2),
    .s_ready   (sr2),
    .s_data    (sd2),
    .s_last    (sl2),
    .ready     (rd2),
    .busy      (busy2),
    .iaddr     (ia2),
    .idata     (id2),
    .err       (er2),
    .frame_cnt (fc2)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: phase 0 = loading, 1 = frame offered, 2 = engine running.
  int ref_mem [4096];
  int m_wp, m_phase, m_err, m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 20) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4096; i++) ref_mem[i] = 0;
    m_wp = 0; m_phase = 0; m_err = 0; m_cnt = 0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, clock, update model.
  task automatic cycle(input bit v, input int d, input bit l, input bit b);
    s_valid = v;
    s_data  = 13'(d);
    s_last  = l;
    busy    = b;
    check("s_ready", s_ready, m_phase == 0);
    check("ready", ready, m_phase == 1);
    check("err", err, m_err);
    check("frame_cnt", frame_cnt, m_cnt);
    tick();
    case (m_phase)
      0: if (v) begin
        ref_mem[m_wp] = d;
        if (m_wp == 4095) begin
          m_wp = 0;
          m_phase = 1;
        end else if (l) begin
          m_err = 1;
          m_wp = 0;
        end else begin
          m_wp++;
        end
      end
      1: if (b) m_phase = 2;
      default: if (!b) begin
        m_phase = 0;
        m_cnt = (m_cnt + 1) % 256;
      end
    endcase
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Compare every buffer word through iaddr; only call when no state change can occur.
  task automatic check_buffer(input string tag);
    for (int a = 0; a < 4096; a++) begin
      iaddr = 12'(a);
      #1;
      check(tag, idata, ref_mem[a]);
    end
    tick();
  endtask

  // Assert reset away from a clock edge, check asynchronous effect, release after an edge.
  task automatic do_reset(input bit scan);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    model_clear();
    check("rst_ready", ready, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_err", err, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    if (scan) check_buffer("rst_buf");
    tick();
    reset = 1'b0;
  endtask

  initial begin
    s_valid = 0; s_last = 0; busy = 0; s_data = 0; iaddr = 0;
    sv2 = 0; sl2 = 0; busy2 = 0; sd2 = 0; ia2 = 0;
    model_clear();

    do_reset(1'b1);

    // Back-to-back full frame: 4096 acceptances in 4096 cycles, then ready.
    for (int i = 0; i < 4096; i++) cycle(1'b1, i % 8192, i == 4095, 1'b0);
    check("ready_after_4096", ready, 1);
    check("s_ready_offer", s_ready, 0);

    // Hand-off with ignored s_valid pulses in OFFER and RUN.
    for (int i = 0; i < 20; i++) cycle(1'($urandom_range(1)), 8191, 1'b0, 1'b0);
    for (int i = 0; i < 500; i++) cycle(1'($urandom_range(1)), 8191, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b0);
    check("frame_cnt_1", frame_cnt, 1);
    check("s_ready_back", s_ready, 1);
    iaddr = 12'd0;    #1; check("rd_0", idata, 0);
    iaddr = 12'd63;   #1; check("rd_63", idata, 63);
    iaddr = 12'd4095; #1; check("rd_4095", idata, 4095);
    check_buffer("frame1_buf");

    // Full frame with random valid gaps into a freshly cleared buffer.
    do_reset(1'b0);
    for (int i = 0; i < 4096; i++) begin
      while ($urandom_range(1) == 1) cycle(1'b0, 0, 1'b0, 1'b0);
      cycle(1'b1, i, i == 4095, 1'b0);
    end
    check("gappy_ready", ready, 1);
    check("gappy_err", err, 0);
    check_buffer("gappy_buf");
    cycle(1'b0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);

    // Early s_last on pixel 100, then a clean frame must land from address 0.
    for (int i = 0; i <= 100; i++) cycle(1'b1, int'($urandom_range(8191)), i == 100, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0);
    check("err_early_last", err, 1);
    for (int i = 0; i < 4096; i++) cycle(1'b1, int'($urandom_range(8191)), i == 4095, 1'b0);
    check("clean_ready", ready, 1);
    check("err_sticky", err, 1);
    check_buffer("clean_buf");

    // Reset while the engine runs; busy stays high and must be ignored in LOAD.
    cycle(1'b0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b1);
    check("in_run_ready", ready, 0);
    do_reset(1'b1);
    cycle(1'b1, 1234, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b1);
    cycle(1'b0, 0, 1'b0, 1'b1);
    iaddr = 12'd0; #1; check("first_after_rst", idata, 1234);
    iaddr = 12'd1; #1; check("second_empty", idata, 0);
    tick();
    busy = 1'b0;

    // Frame counter wrap on the 16-deep instance.
    for (int f = 0; f < 256; f++) begin
      for (int i = 0; i < 16; i++) begin
        sv2 = 1'b1;
        sd2 = 13'((f * 16 + i) % 8192);
        sl2 = (i == 15);
        tick();
      end
      sv2 = 1'b0;
      sl2 = 1'b0;
      check("small_ready", rd2, 1);
      ia2 = 4'd15;
      #1;
      check("small_rd15", id2, (f * 16 + 15) % 8192);
      busy2 = 1'b1;
      tick();
      check("small_s_ready_run", sr2, 0);
      busy2 = 1'b0;
      tick();
      check("small_cnt", fc2, (f + 1) % 256);
    end
    check("small_wrap", fc2, 0);
    check("small_err", er2, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
